fetch_sequencer: RTL and testbench

//  Sequences the 16x32 instruction ROM (memInstrucciones): owns the PC and drives the ROM word address.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_buffer.sv | 45 ++++
 rtl/fetch_sequencer.sv | 126 ++++++++++++
 tb/tb_fetch_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//  Shared definitions for the instruction fetch path: the sequencer state
//  encoding, instruction size, default widths and the NOP encoding.
//  Configuration macro used by the fetch path: FETCH_WRAP_EN (see
//  fetch_sequencer.sv).
// -----------------------------------------------------------------------------
package fetch_pkg;

   localparam int INSTR_BYTES = 4;
   localparam int ADDR_W_DEF  = 4;
   localparam int DATA_W_DEF  = 32;

   localparam logic [31:0] NOP = 32'h0000_0013;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      FETCH = ST_FETCH,
      HALT  = ST_HALT
   } state_t;

endpackage

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//  One-entry valid/ready slot holding a fetched instruction and its PC.
//  Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   load           capture data_in/pc_in and mark the slot valid
//   flush          drop the slot contents (wins over load and accept)
//   data_in, pc_in instruction word and its byte address
//   ready          downstream accepts the slot this cycle
//   valid          slot holds an instruction
//   data, pc       buffered instruction and byte address
// -----------------------------------------------------------------------------
module fetch_buffer #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              flush,
   input  logic [DATA_W-1:0] data_in,
   input  logic [PC_W-1:0]   pc_in,
   input  logic              ready,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [PC_W-1:0]   pc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
         pc    <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= data_in;
         pc    <= pc_in;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//  Owns the PC, drives the instruction ROM word address and registers each
//  fetched word into a one-entry buffer handed to decode with valid/ready.
//  Accepts aligned branch redirects from execute; misaligned targets are
//  dropped and flagged for one cycle.
//  Macro FETCH_WRAP_EN: when defined, fetch wraps from the last ROM word back
//  to word 0 and never halts; when undefined, capturing the last word halts.
//  Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             pulse: leave IDLE and fetch from the current PC
//   redirect_valid    redirect request, target in redirect_pc (byte address)
//   rom_address       ROM word address (PC word index)
//   rom_instruction   combinational ROM read data
//   instr_valid/ready handshake toward decode
//   instr_data/pc     buffered instruction and its byte address
//   halted            high while in HALT
//   misalign_err      pulse after a redirect with a non-word-aligned target
// -----------------------------------------------------------------------------
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              redirect_valid,
   input  logic [ADDR_W+1:0] redirect_pc,
   output logic [ADDR_W-1:0] rom_address,
   input  logic [DATA_W-1:0] rom_instruction,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr_data,
   output logic [ADDR_W+1:0] instr_pc,
   output logic              halted,
   output logic              misalign_err
);

   localparam int PC_W = ADDR_W + 2;
   localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);
   localparam logic [PC_W-1:0] PC_STEP    = PC_W'(INSTR_BYTES);
   localparam logic [PC_W-1:0] LAST_PC    = PC_W'(((2 ** ADDR_W) - 1) * INSTR_BYTES);

`ifdef FETCH_WRAP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   state_t          state, state_nxt;
   logic [PC_W-1:0] pc, pc_nxt;
   logic            active;
   logic            redirect_ok;
   logic            redirect_bad;
   logic            slot_free;
   logic            load;

   // Redirects are only honoured once the sequencer has been started.
   assign active       = (state != IDLE);
   assign redirect_ok  = active && redirect_valid && (redirect_pc[1:0] == 2'b00);
   assign redirect_bad = active && redirect_valid && (redirect_pc[1:0] != 2'b00);

   // A redirect flushes the slot, so no ROM word is captured in that cycle.
   assign slot_free = !instr_valid || instr_ready;
   assign load      = (state == FETCH) && slot_free && !redirect_ok;

   assign rom_address = pc[PC_W-1:2];
   assign halted      = (state == HALT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         pc           <= RESET_PC_V;
         misalign_err <= 1'b0;
      end else begin
         state        <= state_nxt;
         pc           <= pc_nxt;
         misalign_err <= redirect_bad;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      case (state)
         IDLE: begin
            if (start) state_nxt = FETCH;
         end
         FETCH: begin
            if (load) begin
               // PC wraps naturally at 2**PC_W; only the halt decision is configurable.
               pc_nxt = pc + PC_STEP;
               if ((pc == LAST_PC) && !WRAP_EN) state_nxt = HALT;
            end
         end
         HALT: begin
            state_nxt = HALT;
         end
         default: state_nxt = IDLE;
      endcase
      if (redirect_ok) begin
         state_nxt = FETCH;
         pc_nxt    = redirect_pc;
      end
   end

   fetch_buffer #(
      .DATA_W (DATA_W),
      .PC_W   (PC_W)
   ) u_buffer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .flush   (redirect_ok),
      .data_in (rom_instruction),
      .pc_in   (pc),
      .ready   (instr_ready),
      .valid   (instr_valid),
      .data    (instr_data),
      .pc      (instr_pc)
   );

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//  Directed and randomized stimulus for fetch_sequencer with a behavioural
//  reference model of the fetch stream (phase, next fetch address and a
//  queue standing in for the decode-side buffer).
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 32;
   localparam int PC_W   = ADDR_W + 2;
   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int PC_MOD = 2 ** PC_W;

`ifdef FETCH_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              redirect_valid;
   logic [PC_W-1:0]   redirect_pc;
   logic [ADDR_W-1:0] rom_address;
   logic [DATA_W-1:0] rom_instruction;
   logic              instr_valid;
   logic              instr_ready;
   logic [DATA_W-1:0] instr_data;
   logic [PC_W-1:0]   instr_pc;
   logic              halted;
   logic              misalign_err;

   logic [DATA_W-1:0] rom [DEPTH];

   always #5 clk = ~clk;

   assign rom_instruction = rom[rom_address];

   fetch_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(0)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .rom_address     (rom_address),
      .rom_instruction (rom_instruction),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instr_data      (instr_data),
      .instr_pc        (instr_pc),
      .halted          (halted),
      .misalign_err    (misalign_err)
   );

   // Reference model: 0 = not started, 1 = fetching, 2 = stopped at end of ROM.
   int unsigned m_phase;
   int unsigned m_next;               // byte address of next word to fetch
   logic [DATA_W+PC_W-1:0] m_buf[$];  // {data, pc} waiting for decode
   bit          m_err;

   int checks = 0;
   int passes = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_next  = 0;
      m_buf.delete();
      m_err   = 1'b0;
   endtask

   task automatic model_step(input bit st, input bit rv, input int unsigned rpc, input bit rdy);
      bit started;
      started = (m_phase != 0);
      if (started && rv && (rpc % 4 == 0)) begin
         m_buf.delete();
         m_next  = rpc;
         m_phase = 1;
         m_err   = 1'b0;
      end else begin
         m_err = started && rv && (rpc % 4 != 0);
         if (m_buf.size() != 0 && rdy) void'(m_buf.pop_front());
         if (m_phase == 1 && m_buf.size() == 0) begin
            m_buf.push_back({rom[m_next / 4], PC_W'(m_next)});
            if (m_next == (DEPTH - 1) * 4 && !WRAP) m_phase = 2;
            m_next = (m_next + 4) % PC_MOD;
         end else if (m_phase == 0 && st) begin
            m_phase = 1;
         end
      end
   endtask

   task automatic compare(input string where);
      logic [DATA_W+PC_W-1:0] head;
      chk({where, ".valid"}, 64'(instr_valid), 64'(m_buf.size() != 0));
      if (m_buf.size() != 0) begin
         head = m_buf[0];
         chk({where, ".data"}, 64'(instr_data), 64'(head[DATA_W+PC_W-1:PC_W]));
         chk({where, ".pc"}, 64'(instr_pc), 64'(head[PC_W-1:0]));
      end
      chk({where, ".addr"}, 64'(rom_address), 64'(m_next / 4));
      chk({where, ".halted"}, 64'(halted), 64'(m_phase == 2));
      chk({where, ".merr"}, 64'(misalign_err), 64'(m_err));
   endtask

   // Called at posedge+1: drive inputs, advance one clock, then check.
   task automatic step(input string where, input bit st, input bit rv, input int unsigned rpc,
                       input bit rdy);
      start          = st;
      redirect_valid = rv;
      redirect_pc    = PC_W'(rpc);
      instr_ready    = rdy;
      @(posedge clk);
      model_step(st, rv, rpc, rdy);
      #1;
      compare(where);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) rom[i] = 32'hA000_0000 + i;
      start = 0; redirect_valid = 0; redirect_pc = '0; instr_ready = 0;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset.valid", 64'(instr_valid), 64'd0);
      chk("reset.data", 64'(instr_data), 64'd0);
      chk("reset.pc", 64'(instr_pc), 64'd0);
      chk("reset.addr", 64'(rom_address), 64'd0);
      chk("reset.halted", 64'(halted), 64'd0);
      chk("reset.merr", 64'(misalign_err), 64'd0);
      rst_n = 1'b1;

      // Redirect while idle is ignored; start together with redirect takes start only.
      step("idle_redir", 0, 1, 32'h10, 1);
      step("idle_redir2", 0, 1, 32'h11, 1);
      step("start", 1, 1, 32'h10, 1);
      // Stream 0, 4, 8 with ready high.
      for (int i = 0; i < 3; i++) step("stream", 0, 0, 0, 1);
      // Stall three cycles holding pc=8.
      for (int i = 0; i < 3; i++) step("stall", 0, 0, 0, 0);
      step("unstall", 0, 0, 0, 1);
      // Redirect to 0x20 while holding pc=0x0C (transfer still accepted).
      step("redir", 0, 1, 32'h20, 1);
      step("redir_gap", 0, 0, 0, 1);
      step("redir_tgt", 0, 0, 0, 1);
      // Misaligned redirect: flagged and otherwise ignored.
      step("misalign", 0, 1, 32'h22, 1);
      step("misalign_after", 0, 0, 0, 1);
      // Run to the end of ROM.
      for (int i = 0; i < 10; i++) step("to_end", 0, 0, 0, 1);
      // Resume from word 1.
      step("resume", 0, 1, 32'h04, 1);
      for (int i = 0; i < 4; i++) step("resumed", 0, 0, 0, 1);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         bit          st, rv, rdy;
         int unsigned rpc;
         st  = ($urandom_range(0, 15) == 0);
         rv  = ($urandom_range(0, 7) == 0);
         rpc = $urandom_range(0, PC_MOD - 1);
         if ($urandom_range(0, 1) == 0) rpc = rpc & ~32'd3;
         rdy = ($urandom_range(0, 3) != 0);
         step("rand", st, rv, rpc, rdy);
      end

      // Asynchronous reset in the middle of a stall.
      step("pre_rst", 0, 1, 32'h08, 1);
      for (int i = 0; i < 3; i++) step("pre_rst_stall", 0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("arst.valid", 64'(instr_valid), 64'd0);
      chk("arst.addr", 64'(rom_address), 64'd0);
      chk("arst.halted", 64'(halted), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step("post_rst_idle", 0, 0, 0, 1);
      step("restart", 1, 0, 0, 1);
      for (int i = 0; i < 4; i++) step("restarted", 0, 0, 0, 1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
